// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared width helpers and status struct for fifo_stream
package fifo_pkg;

  localparam int unsigned STATUS_CNT_W = 16;

  typedef struct packed {
    logic [STATUS_CNT_W-1:0] count;
    logic                    afull;
    logic                    aempty;
  } fifo_status_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Address width for a store of 'words' entries; never below one bit.
  function automatic int unsigned ptr_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/sram_sd.sv
// rtl/sram_sd.sv - simple dual-port memory, synchronous write, asynchronous read
module sram_sd #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_stream.sv
// rtl/fifo_stream.sv - first-word-fall-through stream FIFO with registered head word
// Optional sticky overflow/underflow flags: define FIFO_STREAM_ERR_EN.
module fifo_stream
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AFULL_THR  = DEPTH - 1,
  parameter int unsigned AEMPTY_THR = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           data_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int unsigned CW        = cnt_width(DEPTH);
  localparam int unsigned MEM_DEPTH = DEPTH - 1;
  localparam int unsigned AW        = ptr_width(MEM_DEPTH);
  localparam int unsigned SW        = STATUS_CNT_W;

  fifo_status_t     status_q;
  logic [SW-1:0]    count_next;
  logic [SW-1:0]    mem_cnt;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mem_rdata;
  logic             push;
  logic             pop;
  logic             load_out;
  logic             mem_empty;
  logic             mem_we;
  logic             mem_re;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(MEM_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign ready_o   = (status_q.count < SW'(DEPTH));
  assign push      = valid_i && ready_o;
  assign pop       = valid_q && ready_i;
  assign mem_cnt   = status_q.count - {{(SW-1){1'b0}}, valid_q};
  assign mem_empty = (mem_cnt == '0);
  // The head register refills whenever it is empty or being consumed.
  assign load_out  = pop || !valid_q;
  assign mem_re    = load_out && !mem_empty;
  // A push into an empty store while the head refills bypasses memory.
  assign mem_we    = push && !(load_out && mem_empty);

  always_comb begin
    count_next = status_q.count;
    if (push && !pop)      count_next = status_q.count + SW'(1);
    else if (pop && !push) count_next = status_q.count - SW'(1);
  end

  sram_sd #(
    .WIDTH (WIDTH),
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      valid_q         <= 1'b0;
      status_q.count  <= '0;
      status_q.afull  <= 1'b0;
      status_q.aempty <= 1'b1;
    end else begin
      if (mem_we)   wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (mem_re)   rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (load_out) valid_q  <= !mem_empty || push;
      status_q.count  <= count_next;
      status_q.afull  <= (count_next >= SW'(AFULL_THR));
      status_q.aempty <= (count_next <= SW'(AEMPTY_THR));
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_out) data_q <= mem_empty ? data_i : mem_rdata;
  end

  assign valid_o        = valid_q;
  assign data_o         = data_q;
  assign count_o        = status_q.count[CW-1:0];
  assign almost_full_o  = status_q.afull;
  assign almost_empty_o = status_q.aempty;

`ifdef FIFO_STREAM_ERR_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (valid_i && !ready_o) overflow_q  <= 1'b1;
      if (ready_i && !valid_q) underflow_q <= 1'b1;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream.sv
// tb/tb_fifo_stream.sv - directed self-checking bench for fifo_stream (WIDTH=8, DEPTH=5)
module tb_fifo_stream;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       valid_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       ready_o;
  logic       valid_o;
  logic [7:0] data_o;
  logic       ready_i = 1'b0;
  logic [2:0] count_o;
  logic       almost_full_o;
  logic       almost_empty_o;
  logic       overflow_o;
  logic       underflow_o;

  int checks = 0;
  int errors = 0;

`ifdef FIFO_STREAM_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  fifo_stream #(.WIDTH(8), .DEPTH(5)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .data_i         (data_i),
    .ready_o        (ready_o),
    .valid_o        (valid_o),
    .data_o         (data_o),
    .ready_i        (ready_i),
    .count_o        (count_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    tick();
    rst_i = 1'b0;
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_o); end
    checks++; if (almost_empty_o !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b want 1", almost_empty_o); end
    checks++; if (almost_full_o !== 1'b0) begin errors++; $display("FAIL reset_afull got %b want 0", almost_full_o); end
    checks++; if ({overflow_o, underflow_o} !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", {overflow_o, underflow_o}); end
  endtask

  task automatic test_single;
    valid_i = 1'b1; data_i = 8'hA5; ready_i = 1'b0;
    tick();
    valid_i = 1'b0;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", valid_o); end
    checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", data_o); end
    checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", count_o); end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    checks++; if ({valid_o, count_o} !== 4'b0_000) begin errors++; $display("FAIL single_pop got v=%b c=%0d want v=0 c=0", valid_o, count_o); end
  endtask

  task automatic test_fill;
    logic [7:0] word;
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      word = 8'h11 + 8'(i);
      valid_i = 1'b1; data_i = word;
      tick();
      checks++; if (count_o !== 3'(i + 1)) begin errors++; $display("FAIL fill_count%0d got %0d want %0d", i, count_o, i + 1); end
      if (i == 1) begin
        checks++; if (almost_empty_o !== 1'b0) begin errors++; $display("FAIL fill_aempty got %b want 0", almost_empty_o); end
      end
    end
    valid_i = 1'b0;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", ready_o); end
    checks++; if (almost_full_o !== 1'b1) begin errors++; $display("FAIL full_afull got %b want 1", almost_full_o); end
    checks++; if (data_o !== 8'h11) begin errors++; $display("FAIL full_head got %h want 11", data_o); end
  endtask

  task automatic test_overflow;
    logic [7:0] word;
    valid_i = 1'b1; data_i = 8'hEE; ready_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    valid_i = 1'b0;
    checks++; if (count_o !== 3'd5) begin errors++; $display("FAIL ovf_count got %0d want 5", count_o); end
    checks++; if (overflow_o !== ERR_EXP) begin errors++; $display("FAIL ovf_flag got %b want %b", overflow_o, ERR_EXP); end
    for (int i = 0; i < 5; i++) begin
      word = 8'h11 + 8'(i);
      checks++; if ({valid_o, data_o} !== {1'b1, word}) begin errors++; $display("FAIL drain%0d got v=%b d=%h want v=1 d=%h", i, valid_o, data_o, word); end
      ready_i = 1'b1;
      tick();
    end
    ready_i = 1'b0;
    checks++; if ({valid_o, count_o} !== 4'b0_000) begin errors++; $display("FAIL drain_empty got v=%b c=%0d want v=0 c=0", valid_o, count_o); end
    checks++; if (overflow_o !== ERR_EXP) begin errors++; $display("FAIL ovf_sticky got %b want %b", overflow_o, ERR_EXP); end
  endtask

  task automatic test_underflow;
    valid_i = 1'b0; ready_i = 1'b1;
    tick();
    tick();
    ready_i = 1'b0;
    checks++; if ({valid_o, count_o} !== 4'b0_000) begin errors++; $display("FAIL unf_state got v=%b c=%0d want v=0 c=0", valid_o, count_o); end
    checks++; if (underflow_o !== ERR_EXP) begin errors++; $display("FAIL unf_flag got %b want %b", underflow_o, ERR_EXP); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++; if ({overflow_o, underflow_o} !== 2'b00) begin errors++; $display("FAIL err_clear got %b want 00", {overflow_o, underflow_o}); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] q[$];
    logic [7:0] word;
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      word = 8'h50 + 8'(i);
      valid_i = 1'b1; data_i = word; q.push_back(word);
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      word = 8'h60 + 8'(k);
      valid_i = 1'b1; data_i = word; ready_i = 1'b1;
      checks++; if ({valid_o, data_o} !== {1'b1, q[0]}) begin errors++; $display("FAIL b2b_data%0d got v=%b d=%h want v=1 d=%h", k, valid_o, data_o, q[0]); end
      tick();
      void'(q.pop_front());
      q.push_back(word);
      checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL b2b_count%0d got %0d want 3", k, count_o); end
    end
    valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({valid_o, data_o} !== {1'b1, q[0]}) begin errors++; $display("FAIL b2b_tail%0d got v=%b d=%h want v=1 d=%h", i, valid_o, data_o, q[0]); end
      ready_i = 1'b1;
      tick();
      void'(q.pop_front());
    end
    ready_i = 1'b0;
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL b2b_end got %0d want 0", count_o); end
  endtask

  task automatic test_reset_mid;
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; data_i = 8'h70 + 8'(i);
      tick();
    end
    checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL mid_pre got %0d want 3", count_o); end
    rst_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1; data_i = 8'h99;
    tick();
    rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    checks++; if ({count_o, valid_o, ready_o} !== 5'b000_0_1) begin errors++; $display("FAIL mid_rst got c=%0d v=%b r=%b want c=0 v=0 r=1", count_o, valid_o, ready_o); end
    valid_i = 1'b1; data_i = 8'h3C;
    tick();
    data_i = 8'h3D;
    tick();
    valid_i = 1'b0;
    checks++; if ({valid_o, data_o, count_o} !== {1'b1, 8'h3C, 3'd2}) begin errors++; $display("FAIL mid_first got v=%b d=%h c=%0d want v=1 d=3c c=2", valid_o, data_o, count_o); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream.md
FIFO_STREAM -- requirements
Module: fifo_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, legal range 1 or more.
REQ-002 SHALL have parameter DEPTH, default 8: total capacity in words, legal range 2 or more; need not be a power of two.
REQ-003 SHALL have parameter AFULL_THR, default DEPTH-1: almost_full_o asserts when count_o is at or above this value.
REQ-004 SHALL have parameter AEMPTY_THR, default 1: almost_empty_o asserts when count_o is at or below this value.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port valid_i, input, 1 bit: a write word is offered.
REQ-008 SHALL have port data_i, input, WIDTH bits: the write data.
REQ-009 SHALL have port ready_o, output, 1 bit: the FIFO can accept a word.
REQ-010 SHALL have port valid_o, output, 1 bit: data_o holds the head word.
REQ-011 SHALL have port data_o, output, WIDTH bits: the head word.
REQ-012 SHALL have port ready_i, input, 1 bit: the consumer takes the head word.
REQ-013 SHALL have port count_o, output, $clog2(DEPTH+1) bits: words held, including the output register.
REQ-014 SHALL have ports almost_full_o and almost_empty_o, output, 1 bit each: threshold flags.
REQ-015 SHALL have ports overflow_o and underflow_o, output, 1 bit each: sticky error flags (see Configuration).

Function
REQ-016 SHALL define push = valid_i && ready_o and pop = valid_o && ready_i; transfers occur only on a rising edge where these are true.
REQ-017 SHALL drive ready_o = (count_o < DEPTH), combinationally from registered state only, with no path from valid_i or ready_i.
REQ-018 SHALL present first-word-fall-through data: data_o is registered and valid whenever valid_o=1, and stays stable while valid_o && !ready_i.
REQ-019 SHALL, for a push into an empty FIFO at edge N, assert valid_o with that word from edge N+1 (one-cycle latency); there SHALL be no combinational path from data_i to data_o.
REQ-020 SHALL sustain one push and one pop per cycle at any count where both are legal, with no bubble on valid_o.
REQ-021 SHALL, on simultaneous push and pop, leave count_o unchanged; at count 1 the pushed word SHALL become the head after the edge.
REQ-022 SHALL update count_o on each edge: +1 on push only, -1 on pop only, unchanged otherwise; count_o SHALL never exceed DEPTH.
REQ-023 SHALL wrap read and write pointers from DEPTH-1 (or the storage limit) to 0 for non-power-of-two DEPTH; full/empty SHALL be derived from the count, not from pointer wrap parity.
REQ-024 SHALL deliver words in write order with no loss or duplication across any pointer wrap.
REQ-025 SHALL register almost_full_o and almost_empty_o so that they reflect the count_o value present after the same edge.

Reset
REQ-026 SHALL, while rst_i=1 at an edge, clear the pointers and count and drive count_o=0, valid_o=0, ready_o=1, almost_empty_o=1, almost_full_o=0, overflow_o=0 and underflow_o=0; data_o value is don't-care.
REQ-027 SHALL, when reset is asserted mid-traffic, discard all stored words and ignore valid_i and ready_i in that cycle.

Configuration
REQ-028 SHALL support macro FIFO_STREAM_ERR_EN; when it is defined, overflow_o SHALL set on any edge with valid_i && !ready_o, underflow_o SHALL set on any edge with ready_i && !valid_o, and both SHALL clear only on reset.
REQ-029 SHALL, when FIFO_STREAM_ERR_EN is undefined, tie overflow_o and underflow_o to 0 and build no error logic.

Structure
REQ-030 SHALL place the count-width helper function and the status struct (count, afull, aempty) in a shared package, fifo_pkg.
REQ-031 SHALL instantiate the existing simple dual-port memory sram_sd for storage, with the output/prefetch register kept in fifo_stream.

Verification
REQ-032 Bench SHALL cover: WIDTH=8, DEPTH=5; push 0x11..0x15 with ready_i=0 -> ready_o=0 after the 5th push, count_o=5, almost_full_o=1, data_o=0x11.
REQ-033 Bench SHALL cover: single push of 0xA5 into an empty FIFO at edge N -> valid_o=1 and data_o=0xA5 from edge N+1, count_o=1.
REQ-034 Bench SHALL cover: 20 cycles of continuous push and pop with DEPTH=5 (pointer wrap) -> output sequence equals input sequence and count_o stays constant.
REQ-035 Bench SHALL cover: a full FIFO with valid_i=1 held for 3 cycles under FIFO_STREAM_ERR_EN -> overflow_o=1 sticky, count_o=5, contents unchanged; without the macro -> overflow_o=0.
REQ-036 Bench SHALL cover: rst_i pulsed while count_o=3 -> next cycle count_o=0, valid_o=0, ready_o=1, and a subsequent push of 0x3C is read out first.
REQ-037 Bench SHALL cover: ready_i=1 on an empty FIFO -> valid_o stays 0, count_o=0, and underflow_o=1 only when the macro is defined.
